// File: rtl/seq_gen_pkg.sv
// Shared types and default configuration for the serial pattern generator.
// The overlap option is selected at build time with SEQGEN_OVERLAP_EN.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 6;
    localparam int CNT_W_DEF = 4;
    localparam int OVL_DEF   = 3;

    localparam logic [5:0] PAT_DEF = 6'b110110;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable MSB-first shift register with a bit index that reloads at the end
// of each repetition; OFS leading bits are skipped on every reload.
module seq_gen_shreg #(
    parameter int PAT_W = 6,
    parameter int OFS   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [PAT_W-1:0] din,
    output logic             tap,
    output logic             last
);

    localparam int IDX_W = $clog2(PAT_W);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sh_q;
    logic [IDX_W-1:0] idx_q;

    // clear zeroes the working register so the tap (and thus out) is 0 outside SHIFT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= '0;
            sh_q  <= '0;
            idx_q <= '0;
        end else if (clear) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            pat_q <= din;
            sh_q  <= din;
            idx_q <= IDX_W'(PAT_W - 1);
        end else if (shift) begin
            if (idx_q == '0) begin
                sh_q  <= pat_q << OFS;
                idx_q <= IDX_W'(PAT_W - 1 - OFS);
            end else begin
                sh_q  <= sh_q << 1;
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    assign tap  = sh_q[PAT_W-1];
    assign last = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial Moore pattern transmitter: sends a latched pattern MSB-first rep_cnt times.
// Build option: define SEQGEN_OVERLAP_EN to share OVL bits between repetitions.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int OVL   = OVL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             ready,
    output logic             busy,
    output logic             out,
    output logic             valid,
    output logic             done
);

    if (PAT_W < 2 || PAT_W > 32 || OVL < 0 || OVL >= PAT_W) begin : g_bad_cfg
        $error("seq_pattern_gen: PAT_W must be 2..32 and OVL must be 0..PAT_W-1");
    end

`ifdef SEQGEN_OVERLAP_EN
    localparam int RELOAD_OFS = OVL;
`else
    localparam int RELOAD_OFS = 0;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] rep_q;
    logic             ready_q;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;

    logic sh_load;
    logic sh_shift;
    logic sh_clear;
    logic sh_tap;
    logic sh_last;
    logic final_bit;

    assign final_bit = (state_q == SHIFT) && sh_last && (rep_q == CNT_W'(1));
    assign sh_load   = (state_q == IDLE) && start && (rep_cnt != '0);
    assign sh_shift  = (state_q == SHIFT);
    assign sh_clear  = final_bit;

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .OFS   (RELOAD_OFS)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .din   (pattern),
        .tap   (sh_tap),
        .last  (sh_last)
    );

    // ready resets low and rises on the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rep_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rep_q   <= rep_cnt;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (rep_cnt != '0) begin
                            state_q <= SHIFT;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        rep_q <= rep_q - 1'b1;
                        if (rep_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign out   = sh_tap;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; expected streams follow SEQGEN_OVERLAP_EN.
module tb_seq_pattern_gen;
    import seq_gen_pkg::*;

    localparam int PAT_W = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] rep_cnt = '0;
    logic             ready;
    logic             busy;
    logic             out;
    logic             valid;
    logic             done;

    int checks = 0;
    int errors = 0;

    seq_pattern_gen #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .OVL   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .rep_cnt (rep_cnt),
        .ready   (ready),
        .busy    (busy),
        .out     (out),
        .valid   (valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    // expected packing: {ready, busy, out, valid, done}
    task automatic chk_outs(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {ready, busy, out, valid, done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed {rdy,bsy,out,vld,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_xfer(input string tag, input logic [PAT_W-1:0] pat,
                            input logic [CNT_W-1:0] rc, input logic [63:0] exp,
                            input int n, input int poke);
        pattern = pat;
        rep_cnt = rc;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pattern = ~pat;
        rep_cnt = '1;
        for (int i = 0; i < n; i++) begin
            chk_outs($sformatf("%s bit%0d", tag, i), {1'b0, 1'b1, exp[n-1-i], 1'b1, 1'b0});
            start = (i == poke);
            @(negedge clk);
        end
        start = 1'b0;
        chk_outs($sformatf("%s done", tag), 5'b01001);
        @(negedge clk);
        chk_outs($sformatf("%s idle", tag), 5'b10000);
    endtask

    initial begin
        // reset held with start asserted
        #1 rst = 1'b0;
        start   = 1'b1;
        pattern = PAT_DEF;
        rep_cnt = 4'd1;
        repeat (3) begin
            @(negedge clk);
            chk_outs("reset", 5'b00000);
        end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_outs("after_reset", 5'b10000);

        run_xfer("single", PAT_DEF, 4'd1, 64'b110110, 6, -1);

`ifdef SEQGEN_OVERLAP_EN
        run_xfer("rep2", PAT_DEF, 4'd2, 64'b110110110, 9, -1);
`else
        run_xfer("rep2", PAT_DEF, 4'd2, 64'b110110110110, 12, -1);
`endif

        run_xfer("zero", PAT_DEF, 4'd0, 64'b0, 0, -1);

`ifdef SEQGEN_OVERLAP_EN
        run_xfer("busy_start", 6'b100111, 4'd2, 64'b100111111, 9, 3);
`else
        run_xfer("busy_start", 6'b100111, 4'd2, 64'b100111100111, 12, 3);
`endif

        // reset during the third bit of a rep_cnt=3 transfer
        pattern = 6'b101101;
        rep_cnt = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_outs("midrst bit0", 5'b01110);
        @(negedge clk);
        chk_outs("midrst bit1", 5'b01010);
        @(negedge clk);
        chk_outs("midrst bit2", 5'b01110);
        #2 rst = 1'b0;
        #1 chk_outs("midrst async", 5'b00000);
        @(negedge clk);
        chk_outs("midrst no_done", 5'b00000);
        rst = 1'b1;
        @(negedge clk);
        chk_outs("midrst release", 5'b10000);

`ifdef SEQGEN_OVERLAP_EN
        run_xfer("fresh", 6'b101101, 4'd2, 64'b101101101, 9, -1);
`else
        run_xfer("fresh", 6'b101101, 4'd2, 64'b101101101101, 12, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial Moore-style pattern transmitter: the driving end of the sequence-detector interface. On a start request it latches a PAT_W-bit pattern and a repetition count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of repetitions. When built with overlap, it emits the overlapping streams that overlapping detectors must flag repeatedly; for example, 110110 with overlap 3 emits 110110110. It sits upstream of the sequence detectors as stimulus/traffic source and in-system pattern injector.

## Interface
- PAT_W, 6, pattern length in bits, 2..32
- CNT_W, 4, width of repetition count
- OVL, 3, overlap bits between consecutive repetitions; 0 ≤ OVL < PAT_W; used only with SEQGEN_OVERLAP_EN
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  transfer request, sampled only when ready=1
- pattern  input  PAT_W  pattern to send, sampled with start
- rep_cnt  input  CNT_W  number of repetitions, sampled with start
- ready  output  1  idle, start accepted
- busy  output  1  transfer in progress (SHIFT or DONE)
- out  output  1  serial data bit
- valid  output  1  out carries a pattern bit this cycle
- done  output  1  one-cycle pulse after the last bit

## Operation
- States: IDLE, SHIFT, DONE. Registered Moore outputs only; no combinational path from inputs to outputs.
- IDLE:
  - ready=1, busy=0, valid=0, out=0.
  - start=1 latches pattern into a shift register and rep_cnt into the repetition counter.
  - Goes to SHIFT if rep_cnt≠0.
  - Goes to DONE if rep_cnt=0: no bits sent, done still pulses.
- SHIFT:
  - valid=1; out = current pattern bit, MSB first.
  - Bit index counts PAT_W-1 down to 0.
  - At index 0 the repetition counter decrements.
  - If it reaches 0, go to DONE.
  - Otherwise reload the index (see Configuration) and stay in SHIFT with no gap cycle.
- DONE: done=1, valid=0, busy=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; pattern and rep_cnt changes during a transfer have no effect.
- Total valid bits: PAT_W·R without overlap; PAT_W + (R−1)·(PAT_W−OVL) with overlap.
- Counters saturate never; widths are ceil(log2(PAT_W)) for the index and CNT_W for repetitions.

## Timing
- Reset values: state=IDLE, ready=1 (0 while rst low), busy=0, out=0, valid=0, done=0. The shift register and counters clear.
- Start latency: start sampled at edge N means the first bit (pattern[PAT_W-1]) appears on out/valid after edge N, for cycle N+1.
- Each bit is held exactly one cycle; valid is continuous for the whole transfer.
- done is high the cycle after the last valid bit; ready returns the cycle after done.
- Back-to-back: start held high is accepted in the first IDLE cycle after done. Minimum gap between transfers is 2 cycles (DONE + IDLE).
- rep_cnt=0: done is high the cycle after start; valid never asserts.
- Reset mid-transfer: all outputs drop immediately (asynchronously); the in-flight transfer is discarded with no done pulse.
- Reset release is synchronous to clk in effect: the first start is recognized at the first rising edge with rst high.

## Configuration
- SEQGEN_OVERLAP_EN defined:
  - After the first repetition, the index reloads to PAT_W-1-OVL, so the first OVL bits of later repetitions are not re-sent.
  - OVL=0 behaves as non-overlap.
- SEQGEN_OVERLAP_EN undefined:
  - The index always reloads to PAT_W-1; full patterns go back-to-back.
  - OVL is ignored.

## Structure
- Shared package seq_gen_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - default PAT_W/CNT_W/OVL constants
  - default pattern constant 6'b110110
- One sub-module, seq_gen_shreg: loadable PAT_W-bit shift register with MSB tap and index reload, used by the FSM top.

## Test plan
- Reset: hold rst low 3 cycles with start=1 → ready=0, valid=0, done=0, out=0. After release, ready=1.
- Single pattern, pattern=110110, rep_cnt=1 → out=1,1,0,1,1,0 on 6 consecutive valid cycles, then done for 1 cycle, then ready.
- Overlap (macro on, OVL=3), pattern=110110, rep_cnt=2 → out=110110110 (9 valid cycles). Looped into the overlapping 110110 detector, detect fires twice.
- No overlap (macro off), same stimulus → 110110110110 (12 valid cycles), then done.
- rep_cnt=0 → valid never high; done high the cycle after start. Also, start pulsed during a busy transfer → ignored, and the bit stream is unchanged.
- rst asserted on the 3rd bit of a rep_cnt=3 transfer → outputs 0 immediately, no done. A new start after release sends a fresh full transfer.
